ecc_field_alu: RTL and testbench

ECC_FIELD_ALU -- requirements
Module: ecc_field_alu

---
 rtl/ecc_field_pkg.sv | 37 +++
 rtl/ecc_modmul.sv | 80 ++++++++
 rtl/ecc_field_alu.sv | 234 +++++++++++++++++++++++
 tb/tb_ecc_field_alu.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_field_pkg.sv
// Shared types and secp256k1 constants for the prime-field ALU.
// The INV states exist only when ECC_FIELD_ALU_INV_EN is defined.
package ecc_field_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_INV = 2'd3
  } op_e;

`ifdef ECC_FIELD_ALU_INV_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARITH   = 3'd1,
    MUL     = 3'd2,
    INV_SQ  = 3'd3,
    INV_MUL = 3'd4,
    RESP    = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARITH = 3'd1,
    MUL   = 3'd2,
    RESP  = 3'd5
  } state_e;
`endif

  localparam logic [255:0] SECP_P  =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] SECP_GX =
    256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [255:0] SECP_GY =
    256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;

endpackage

// File: rtl/ecc_modmul.sv
// Bit-serial interleaved modular multiplier, MSB-first over b.
// Loads on start, done pulses WIDTH+1 cycles after the start cycle.
module ecc_modmul
  import ecc_field_pkg::*;
#(
  parameter int unsigned      WIDTH   = 256,
  parameter logic [WIDTH-1:0] MODULUS = WIDTH'(SECP_P)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH+1:0] step_c;

  // acc < M and a < M keep 2*acc + a below 3M, so two subtracts suffice
  always_comb begin
    step_c = {1'b0, acc_q, 1'b0} + (b_q[WIDTH-1] ? {2'b00, a_q} : '0);
    if (step_c >= {2'b00, MODULUS}) step_c = step_c - {2'b00, MODULUS};
    if (step_c >= {2'b00, MODULUS}) step_c = step_c - {2'b00, MODULUS};

    acc_d  = acc_q;
    a_d    = a_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (busy_q) begin
      acc_d = WIDTH'(step_c);
      b_d   = b_q << 1;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      acc_d  = '0;
      a_d    = a;
      b_d    = b;
      cnt_d  = CW'(WIDTH);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = acc_q;

endmodule

// File: rtl/ecc_field_alu.sv
// Prime-field ADD/SUB/MUL/INV unit with a single in-flight request.
// INV (Fermat exponentiation) is built only with ECC_FIELD_ALU_INV_EN.
module ecc_field_alu
  import ecc_field_pkg::*;
#(
  parameter int unsigned      WIDTH   = 256,
  parameter logic [WIDTH-1:0] MODULUS = WIDTH'(SECP_P)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             err_q, err_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             phase_q, phase_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             req_bad_c;
  logic             mul_start_c;
  logic [WIDTH-1:0] mul_a_c, mul_b_c;
  logic             mul_busy, mul_done;
  logic [WIDTH-1:0] mul_res;

`ifdef ECC_FIELD_ALU_INV_EN
  localparam int unsigned      IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] EXP = MODULUS - WIDTH'(2);
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] r_q, r_d;
`endif

  // Early errors take ARITH's two-cycle path with no arithmetic performed
  always_comb begin
    req_bad_c = (req_a >= MODULUS);
    if (op_e'(req_op) != OP_INV) begin
      req_bad_c = req_bad_c || (req_b >= MODULUS);
    end else begin
`ifdef ECC_FIELD_ALU_INV_EN
      req_bad_c = req_bad_c || (req_a == '0);
`else
      req_bad_c = 1'b1;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    err_d       = err_q;
    sum_d       = sum_q;
    phase_d     = phase_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    mul_start_c = 1'b0;
    mul_a_c     = a_q;
    mul_b_c     = b_q;
`ifdef ECC_FIELD_ALU_INV_EN
    idx_d       = idx_q;
    r_d         = r_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = op_e'(req_op);
          a_d     = req_a;
          b_d     = req_b;
          err_d   = req_bad_c;
          phase_d = 1'b0;
          if (req_bad_c) begin
            state_d = ARITH;
          end else begin
            case (op_e'(req_op))
              OP_MUL: state_d = MUL;
`ifdef ECC_FIELD_ALU_INV_EN
              OP_INV: begin
                state_d = INV_SQ;
                r_d     = WIDTH'(1);
                idx_d   = IW'(WIDTH - 1);
              end
`endif
              default: state_d = ARITH;
            endcase
          end
        end
      end
      ARITH: begin
        if (!phase_q) begin
          sum_d   = (op_q == OP_SUB) ? ({1'b0, a_q} - {1'b0, b_q})
                                     : ({1'b0, a_q} + {1'b0, b_q});
          phase_d = 1'b1;
        end else begin
          state_d   = RESP;
          rsp_err_d = err_q;
          if (err_q) begin
            rsp_data_d = '0;
          end else if (op_q == OP_SUB) begin
            rsp_data_d = sum_q[WIDTH] ? (sum_q[WIDTH-1:0] + MODULUS) : sum_q[WIDTH-1:0];
          end else begin
            rsp_data_d = (sum_q >= {1'b0, MODULUS}) ? WIDTH'(sum_q - {1'b0, MODULUS})
                                                    : sum_q[WIDTH-1:0];
          end
        end
      end
      MUL: begin
        if (mul_done) begin
          state_d    = RESP;
          rsp_data_d = mul_res;
          rsp_err_d  = 1'b0;
        end else if (!mul_busy) begin
          mul_start_c = 1'b1;
        end
      end
`ifdef ECC_FIELD_ALU_INV_EN
      // Square for exponent bit idx; a finished product feeds the next start directly
      INV_SQ: begin
        if (mul_done) begin
          r_d     = mul_res;
          mul_a_c = mul_res;
          mul_b_c = mul_res;
          if (EXP[idx_q]) begin
            state_d     = INV_MUL;
            mul_b_c     = a_q;
            mul_start_c = 1'b1;
          end else if (idx_q == '0) begin
            state_d    = RESP;
            rsp_data_d = mul_res;
            rsp_err_d  = 1'b0;
          end else begin
            idx_d       = idx_q - IW'(1);
            mul_start_c = 1'b1;
          end
        end else if (!mul_busy) begin
          mul_a_c     = r_q;
          mul_b_c     = r_q;
          mul_start_c = 1'b1;
        end
      end
      INV_MUL: begin
        if (mul_done) begin
          r_d = mul_res;
          if (idx_q == '0) begin
            state_d    = RESP;
            rsp_data_d = mul_res;
            rsp_err_d  = 1'b0;
          end else begin
            state_d     = INV_SQ;
            idx_d       = idx_q - IW'(1);
            mul_a_c     = mul_res;
            mul_b_c     = mul_res;
            mul_start_c = 1'b1;
          end
        end
      end
`endif
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      err_q       <= 1'b0;
      sum_q       <= '0;
      phase_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
`ifdef ECC_FIELD_ALU_INV_EN
      idx_q       <= '0;
      r_q         <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      err_q       <= err_d;
      sum_q       <= sum_d;
      phase_q     <= phase_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
`ifdef ECC_FIELD_ALU_INV_EN
      idx_q       <= idx_d;
      r_q         <= r_d;
`endif
    end
  end

  ecc_modmul #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_modmul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start_c),
    .a      (mul_a_c),
    .b      (mul_b_c),
    .busy   (mul_busy),
    .done   (mul_done),
    .result (mul_res)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ecc_field_alu.sv
// Bench for ecc_field_alu: an 8-bit/251 instance for vectors and random ops,
// plus a default 256-bit secp256k1 instance for wide multiplies.
module tb_ecc_field_alu;
  import ecc_field_pkg::*;

`ifdef ECC_FIELD_ALU_INV_EN
  localparam bit INV_BUILD = 1'b1;
`else
  localparam bit INV_BUILD = 1'b0;
`endif
  localparam int SM        = 251;
  localparam int INV_BOUND = 2 * 8 * 9 + 4;
  localparam int BIG_LAT   = 258;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready, s_rsp_err;
  logic [1:0] s_req_op;
  logic [7:0] s_req_a, s_req_b, s_rsp_data;

  logic         b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [1:0]   b_req_op;
  logic [255:0] b_req_a, b_req_b, b_rsp_data;

  ecc_field_alu #(.WIDTH(8), .MODULUS(8'd251)) dut_small (
    .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_op(s_req_op), .req_a(s_req_a), .req_b(s_req_b), .rsp_valid(s_rsp_valid),
    .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data), .rsp_err(s_rsp_err)
  );

  ecc_field_alu dut_big (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_op(b_req_op), .req_a(b_req_a), .req_b(b_req_b), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] op;
    int         a;
    int         b;
    int         d;
    bit         e;
    int         lat;   // -1: only bounded by INV_BOUND
  } vec_t;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Field arithmetic from the definitions; inverse by exhaustive search
  function automatic void model(input int op, input int a, input int b, output int d, output bit e);
    d = 0;
    e = 1'b0;
    if (a >= SM || (op != 3 && b >= SM)) begin
      e = 1'b1;
    end else begin
      case (op)
        0: d = (a + b) % SM;
        1: d = (a - b + SM) % SM;
        2: d = (a * b) % SM;
        default: begin
          if (!INV_BUILD || a == 0) e = 1'b1;
          else for (int x = 1; x < SM; x++) if ((a * x) % SM == 1) d = x;
        end
      endcase
    end
  endfunction

  function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] p;
    p = {256'd0, a} * {256'd0, b};
    return 256'(p % {256'd0, SECP_P});
  endfunction

  function automatic logic [255:0] powmod(input logic [255:0] base, input logic [255:0] ex);
    logic [255:0] r, bb;
    r  = 256'd1;
    bb = base;
    for (int i = 0; i < 256; i++) begin
      if (ex[i]) r = mulmod(r, bb);
      bb = mulmod(bb, bb);
    end
    return r;
  endfunction

  // Issue one request, wait for the response, then consume it
  task automatic issue(input bit big, input logic [1:0] op, input logic [255:0] a,
                       input logic [255:0] b, output logic [255:0] d, output logic e,
                       output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    @(negedge clk);
    if (big) begin
      b_req_op = op; b_req_a = a; b_req_b = b; b_req_valid = 1'b1;
    end else begin
      s_req_op = op; s_req_a = a[7:0]; s_req_b = b[7:0]; s_req_valid = 1'b1;
    end
    check("req_ready_idle", 256'(big ? b_req_ready : s_req_ready), 256'(1));
    @(posedge clk);
    #1;
    s_req_valid = 1'b0;
    b_req_valid = 1'b0;
    for (int i = 1; i <= 1000 && !got; i++) begin
      @(posedge clk);
      #1;
      if (big ? b_rsp_valid : s_rsp_valid) begin
        got = 1'b1;
        lat = i;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: no rsp_valid within 1000 cycles, required a response");
    end
    d = big ? b_rsp_data : 256'(s_rsp_data);
    e = big ? b_rsp_err : s_rsp_err;
    @(negedge clk);
    if (big) b_rsp_ready = 1'b1; else s_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    s_rsp_ready = 1'b0;
    b_rsp_ready = 1'b0;
    check("rsp_valid_clears", 256'(big ? b_rsp_valid : s_rsp_valid), 256'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[$];
    logic [255:0] d;
    logic         e;
    int           lat, ed, elat;
    bit           ee, seen;
    logic [255:0] inv_gx;
    logic [7:0]   held;

    rst = 1'b1;
    s_req_valid = 1'b0; s_req_op = 2'd0; s_req_a = '0; s_req_b = '0; s_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_op = 2'd0; b_req_a = '0; b_req_b = '0; b_rsp_ready = 1'b0;
    #2;
    check("rst_req_ready", 256'(s_req_ready), 256'(1));
    check("rst_rsp_valid", 256'(s_rsp_valid), 256'(0));
    check("rst_rsp_data", 256'(s_rsp_data), 256'(0));
    check("rst_rsp_err", 256'(s_rsp_err), 256'(0));
    check("rst_big_req_ready", 256'(b_req_ready), 256'(1));
    check("rst_big_rsp_valid", 256'(b_rsp_valid), 256'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // rsp_ready with nothing pending changes nothing
    s_rsp_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("idle_rsp_ready_valid", 256'(s_rsp_valid), 256'(0));
      check("idle_rsp_ready_ready", 256'(s_req_ready), 256'(1));
    end
    s_rsp_ready = 1'b0;

    vecs.push_back('{2'd0, 250, 3, 2, 1'b0, 2});
    vecs.push_back('{2'd1, 3, 5, 249, 1'b0, 2});
    vecs.push_back('{2'd2, 200, 200, 91, 1'b0, 10});
    vecs.push_back('{2'd0, 251, 0, 0, 1'b1, -1});
    vecs.push_back('{2'd0, 0, 250, 250, 1'b0, 2});
    vecs.push_back('{2'd1, 0, 0, 0, 1'b0, 2});
    vecs.push_back('{2'd1, 250, 0, 250, 1'b0, 2});
    vecs.push_back('{2'd2, 250, 250, 1, 1'b0, 10});
    vecs.push_back('{2'd2, 0, 77, 0, 1'b0, 10});
    vecs.push_back('{2'd2, 5, 251, 0, 1'b1, -1});
    if (INV_BUILD) begin
      vecs.push_back('{2'd3, 3, 0, 84, 1'b0, -1});
      vecs.push_back('{2'd3, 0, 0, 0, 1'b1, -1});
      vecs.push_back('{2'd3, 1, 0, 1, 1'b0, -1});
      vecs.push_back('{2'd3, 250, 0, 250, 1'b0, -1});
    end else begin
      vecs.push_back('{2'd3, 3, 0, 0, 1'b1, 2});
      vecs.push_back('{2'd3, 0, 9, 0, 1'b1, 2});
    end

    foreach (vecs[i]) begin
      issue(1'b0, vecs[i].op, 256'(vecs[i].a), 256'(vecs[i].b), d, e, lat);
      check($sformatf("vec%0d_data", i), d, 256'(vecs[i].d));
      check($sformatf("vec%0d_err", i), 256'(e), 256'(vecs[i].e));
      if (vecs[i].lat >= 0) check($sformatf("vec%0d_latency", i), 256'(lat), 256'(vecs[i].lat));
      else check($sformatf("vec%0d_latency_bound", i), 256'(lat <= INV_BOUND), 256'(1));
    end

    for (int n = 0; n < 40; n++) begin
      int op, a, b;
      op = $urandom_range(0, 3);
      a  = (n % 8 == 7) ? $urandom_range(0, 255) : $urandom_range(0, SM - 1);
      b  = (n % 8 == 5) ? $urandom_range(0, 255) : $urandom_range(0, SM - 1);
      model(op, a, b, ed, ee);
      if (op == 3 && !INV_BUILD) elat = 2;
      else if (ee || op == 3) elat = -1;
      else elat = (op == 2) ? 10 : 2;
      issue(1'b0, 2'(op), 256'(a), 256'(b), d, e, lat);
      check($sformatf("rnd%0d_op%0d_data", n, op), d, 256'(ed));
      check($sformatf("rnd%0d_op%0d_err", n, op), 256'(e), 256'(ee));
      if (elat >= 0) check($sformatf("rnd%0d_latency", n), 256'(lat), 256'(elat));
      else check($sformatf("rnd%0d_latency_bound", n), 256'(lat <= INV_BOUND), 256'(1));
    end

    // Backpressure: response held, new request ignored
    @(negedge clk);
    s_req_op = 2'd2; s_req_a = 8'd7; s_req_b = 8'd9; s_req_valid = 1'b1;
    @(posedge clk);
    #1;
    s_req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = s_rsp_valid;
    end
    check("bp_rsp_seen", 256'(seen), 256'(1));
    check("bp_data", 256'(s_rsp_data), 256'(63));
    held = s_rsp_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_req_op = 2'd0; s_req_a = 8'd1; s_req_b = 8'd1; s_req_valid = 1'b1;
      @(posedge clk);
      #1;
      check("bp_valid_held", 256'(s_rsp_valid), 256'(1));
      check("bp_data_stable", 256'(s_rsp_data), 256'(held));
      check("bp_req_ready_low", 256'(s_req_ready), 256'(0));
    end
    @(negedge clk);
    s_req_valid = 1'b0;
    s_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    s_rsp_ready = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (s_rsp_valid) seen = 1'b1;
    end
    check("bp_no_queued_rsp", 256'(seen), 256'(0));

    // Reset in the middle of a multiply
    @(negedge clk);
    s_req_op = 2'd2; s_req_a = 8'd11; s_req_b = 8'd13; s_req_valid = 1'b1;
    @(posedge clk);
    #1;
    s_req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", 256'(s_rsp_valid), 256'(0));
    check("midrst_req_ready", 256'(s_req_ready), 256'(1));
    check("midrst_rsp_data", 256'(s_rsp_data), 256'(0));
    check("midrst_rsp_err", 256'(s_rsp_err), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (s_rsp_valid) seen = 1'b1;
    end
    check("midrst_no_stale_rsp", 256'(seen), 256'(0));
    issue(1'b0, 2'd0, 256'(100), 256'(200), d, e, lat);
    check("post_rst_add_data", d, 256'(49));
    check("post_rst_add_err", 256'(e), 256'(0));
    check("post_rst_add_latency", 256'(lat), 256'(2));

    // Full-width secp256k1 instance
    issue(1'b1, 2'd2, SECP_GX, 256'd1, d, e, lat);
    check("big_mul_gx_1", d, SECP_GX);
    check("big_mul_gx_1_latency", 256'(lat), 256'(BIG_LAT));
    issue(1'b1, 2'd2, SECP_GX, SECP_GY, d, e, lat);
    check("big_mul_gx_gy", d, mulmod(SECP_GX, SECP_GY));
    check("big_mul_gx_gy_err", 256'(e), 256'(0));
    inv_gx = powmod(SECP_GX, SECP_P - 256'd2);
    issue(1'b1, 2'd2, SECP_GX, inv_gx, d, e, lat);
    check("big_mul_gx_invgx", d, 256'd1);
    issue(1'b1, 2'd0, SECP_P - 256'd1, 256'd2, d, e, lat);
    check("big_add_wrap", d, 256'd1);
    check("big_add_latency", 256'(lat), 256'(2));
    issue(1'b1, 2'd1, 256'd0, 256'd1, d, e, lat);
    check("big_sub_wrap", d, SECP_P - 256'd1);
    if (!INV_BUILD) begin
      issue(1'b1, 2'd3, SECP_GX, 256'd0, d, e, lat);
      check("big_inv_disabled_data", d, 256'd0);
      check("big_inv_disabled_err", 256'(e), 256'(1));
      check("big_inv_disabled_latency", 256'(lat), 256'(2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
